// File: rtl/bit_error_meter.sv
// bit_error_meter: windowed bit/symbol error counter comparing received 2-bit
// symbols against a latency-aligned copy of the transmitted stream.
module bit_error_meter #(
    parameter int WIN = 1100,
    parameter int DLY = 0,
    parameter int CW  = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    din_ref,
    input  logic [1:0]    din_rx,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] bit_err_cnt,
    output logic [CW-1:0] sym_err_cnt,
    output logic          err_flag
);
    localparam int SW = $clog2(WIN + 1);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FLUSH = 2'd1;
    localparam logic [1:0] COUNT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [SW-1:0] sym_cnt;
    logic [3:0]    fl_cnt;
    logic [1:0]    ref_aligned;
    logic [1:0]    mism;
    logic [1:0]    nbit;
    logic          serr;
    logic          go;
    logic [CW:0]   bsum;
    logic [CW:0]   ssum;

    generate
        if (DLY == 0) begin : g_nodly
            assign ref_aligned = din_ref;
        end else begin : g_dly
            logic [1:0] dl [DLY];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < DLY; i++) dl[i] <= 2'b00;
                end else begin
                    dl[0] <= din_ref;
                    for (int i = 1; i < DLY; i++) dl[i] <= dl[i-1];
                end
            end
            assign ref_aligned = dl[DLY-1];
        end
    endgenerate

    assign mism = ref_aligned ^ din_rx;
    assign nbit = {1'b0, mism[1]} + {1'b0, mism[0]};
    assign serr = |mism;
    assign go   = start && (state == IDLE || state == DONE);
    assign busy = state == FLUSH || state == COUNT;
    // one extra bit of headroom detects overflow for saturation
    assign bsum = {1'b0, bit_err_cnt} + {{(CW-1){1'b0}}, nbit};
    assign ssum = {1'b0, sym_err_cnt} + {{CW{1'b0}}, serr};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            done        <= 1'b0;
            err_flag    <= 1'b0;
            bit_err_cnt <= '0;
            sym_err_cnt <= '0;
            sym_cnt     <= '0;
            fl_cnt      <= '0;
        end else begin
            err_flag <= serr;
            done     <= state == DONE;
            if (go) begin
                bit_err_cnt <= '0;
                sym_err_cnt <= '0;
                sym_cnt     <= '0;
                fl_cnt      <= '0;
                state       <= (DLY > 0) ? FLUSH : COUNT;
            end else begin
                case (state)
                    FLUSH: begin
                        fl_cnt <= fl_cnt + 4'd1;
                        if (fl_cnt == 4'(DLY - 1)) state <= COUNT;
                    end
                    COUNT: begin
                        bit_err_cnt <= bsum[CW] ? '1 : bsum[CW-1:0];
                        sym_err_cnt <= ssum[CW] ? '1 : ssum[CW-1:0];
                        sym_cnt     <= sym_cnt + 1'b1;
                        if (sym_cnt == SW'(WIN - 1)) state <= DONE;
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bit_error_meter.sv
// tb_bit_error_meter: directed vectors and window-level sequences for bit_error_meter
// across four parameterisations sharing one clock and reset.
module tb_bit_error_meter;
    logic clk = 1'b0;
    logic reset;
    logic st_a, st_b, st_c, st_d;
    logic [1:0] ref_a, rx_a, ref_b, rx_b, ref_c, rx_c, ref_d, rx_d;
    logic busy_a, done_a, ef_a, busy_b, done_b, ef_b, busy_c, done_c, ef_c, busy_d, done_d, ef_d;
    logic [15:0] bec_a, sec_a, bec_b, sec_b, bec_d, sec_d;
    logic [3:0] bec_c, sec_c;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_error_meter #(.WIN(1100), .DLY(0), .CW(16)) u_a (.clk(clk), .reset(reset), .start(st_a), .din_ref(ref_a), .din_rx(rx_a),
        .busy(busy_a), .done(done_a), .bit_err_cnt(bec_a), .sym_err_cnt(sec_a), .err_flag(ef_a));
    bit_error_meter #(.WIN(20), .DLY(3), .CW(16)) u_b (.clk(clk), .reset(reset), .start(st_b), .din_ref(ref_b), .din_rx(rx_b),
        .busy(busy_b), .done(done_b), .bit_err_cnt(bec_b), .sym_err_cnt(sec_b), .err_flag(ef_b));
    bit_error_meter #(.WIN(20), .DLY(0), .CW(4)) u_c (.clk(clk), .reset(reset), .start(st_c), .din_ref(ref_c), .din_rx(rx_c),
        .busy(busy_c), .done(done_c), .bit_err_cnt(bec_c), .sym_err_cnt(sec_c), .err_flag(ef_c));
    bit_error_meter #(.WIN(8), .DLY(0), .CW(16)) u_d (.clk(clk), .reset(reset), .start(st_d), .din_ref(ref_d), .din_rx(rx_d),
        .busy(busy_d), .done(done_d), .bit_err_cnt(bec_d), .sym_err_cnt(sec_d), .err_flag(ef_d));

    typedef struct {
        logic [1:0] r;
        logic [1:0] x;
        logic       f;
        logic       b;
        int         be;
        int         se;
    } vec_t;
    vec_t tv [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    initial begin
        int n, bsy, eff, dn;
        logic [1:0] h [3];
        logic [1:0] r;
        tv[0] = '{2'd0, 2'd0, 1'b0, 1'b1, 0, 0};
        tv[1] = '{2'd1, 2'd0, 1'b1, 1'b1, 1, 1};
        tv[2] = '{2'd2, 2'd1, 1'b1, 1'b1, 3, 2};
        tv[3] = '{2'd3, 2'd3, 1'b0, 1'b1, 3, 2};
        tv[4] = '{2'd3, 2'd1, 1'b1, 1'b1, 4, 3};
        tv[5] = '{2'd0, 2'd3, 1'b1, 1'b1, 6, 4};
        tv[6] = '{2'd2, 2'd2, 1'b0, 1'b1, 6, 4};
        tv[7] = '{2'd1, 2'd2, 1'b1, 1'b0, 8, 5};
        reset = 1'b0;
        {st_a, st_b, st_c, st_d} = '0;
        {ref_b, rx_b, ref_c, rx_c, ref_d, rx_d} = '0;
        ref_a = 2'd3;
        rx_a  = 2'd0;
        tick();
        tick();
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_bec", int'(bec_a), 0);
        chk("rst_sec", int'(sec_a), 0);
        chk("rst_ef", int'(ef_a), 0);
        reset = 1'b1;
        ref_a = 2'd0;
        tick();

        // table-driven window of 8 symbols on u_d
        st_d = 1'b1;
        tick();
        st_d = 1'b0;
        chk("d_busy_start", int'(busy_d), 1);
        for (int i = 0; i < 8; i++) begin
            ref_d = tv[i].r;
            rx_d  = tv[i].x;
            tick();
            chk($sformatf("d_ef_%0d", i), int'(ef_d), int'(tv[i].f));
            chk($sformatf("d_busy_%0d", i), int'(busy_d), int'(tv[i].b));
            chk($sformatf("d_bec_%0d", i), int'(bec_d), tv[i].be);
            chk($sformatf("d_sec_%0d", i), int'(sec_d), tv[i].se);
            chk($sformatf("d_done_%0d", i), int'(done_d), 0);
        end
        ref_d = 2'd0;
        rx_d  = 2'd3;
        tick();
        chk("d_done_pulse", int'(done_d), 1);
        tick();
        chk("d_done_low", int'(done_d), 0);
        chk("d_hold_bec", int'(bec_d), 8);
        chk("d_hold_sec", int'(sec_d), 5);

        // clean link, full 1100-symbol window
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        n = 0;
        while (!done_a && n < 2000) begin
            ref_a = 2'($urandom);
            rx_a  = ref_a;
            tick();
            n++;
        end
        chk("a1_done_edge", n, 1101);
        chk("a1_bec", int'(bec_a), 0);
        chk("a1_sec", int'(sec_a), 0);

        // period-11 double-bit injector, with a stray start mid-window
        st_a = 1'b1;
        tick();
        st_a = 1'b0;
        n = 0;
        while (!done_a && n < 2000) begin
            n++;
            ref_a = 2'($urandom);
            rx_a  = (n % 11 == 0) ? ref_a ^ 2'b11 : ref_a;
            st_a  = (n == 500);
            tick();
        end
        st_a = 1'b0;
        chk("a2_done_edge", n, 1101);
        chk("a2_bec", int'(bec_a), 200);
        chk("a2_sec", int'(sec_a), 100);

        // latency-3 channel on u_b
        h[0] = 2'd0;
        h[1] = 2'd0;
        h[2] = 2'd0;
        st_b = 1'b1;
        tick();
        st_b = 1'b0;
        bsy = int'(busy_b);
        eff = 0;
        n = 0;
        while (!done_b && n < 200) begin
            n++;
            r = 2'($urandom);
            rx_b  = h[2];
            ref_b = r;
            tick();
            h[2] = h[1];
            h[1] = h[0];
            h[0] = r;
            bsy += int'(busy_b);
            eff |= int'(ef_b);
        end
        chk("b_done_edge", n, 24);
        chk("b_busy_cycles", bsy, 23);
        chk("b_err_flag", eff, 0);
        chk("b_bec", int'(bec_b), 0);
        chk("b_sec", int'(sec_b), 0);

        // inverted link saturates CW=4 counts
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        n = 0;
        while (!done_c && n < 200) begin
            n++;
            ref_c = 2'($urandom);
            rx_c  = ~ref_c;
            tick();
        end
        chk("c_done_edge", n, 21);
        chk("c_bec_sat", int'(bec_c), 15);
        chk("c_sec_sat", int'(sec_c), 15);

        // reset in the middle of a window
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ref_c = 2'($urandom);
            rx_c  = ~ref_c;
            tick();
        end
        reset = 1'b0;
        #1;
        chk("c_rst_busy", int'(busy_c), 0);
        chk("c_rst_bec", int'(bec_c), 0);
        chk("c_rst_sec", int'(sec_c), 0);
        tick();
        tick();
        reset = 1'b1;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            dn += int'(done_c);
        end
        chk("c_rst_no_done", dn, 0);
        st_c = 1'b1;
        tick();
        st_c = 1'b0;
        n = 0;
        while (!done_c && n < 200) begin
            n++;
            ref_c = 2'($urandom);
            rx_c  = (n == 5) ? ref_c ^ 2'b01 : ref_c;
            tick();
        end
        chk("c_fresh_done_edge", n, 21);
        chk("c_fresh_bec", int'(bec_c), 1);
        chk("c_fresh_sec", int'(sec_c), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
